// File: rtl/easy_axi_txn_seq_if.sv
// Command and transaction handshake bundle for the EASY_AXI command sequencer.
// master: the sequencer (accepts commands, drives txn_start/txn_type).
// slave:  the environment (pushes commands, returns txn_done).
interface easy_axi_txn_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic       txn_start;
  logic [1:0] txn_type;
  logic       txn_done;

  modport master (
    input  cmd_valid,
    input  cmd_type,
    input  txn_done,
    output cmd_ready,
    output txn_start,
    output txn_type
  );

  modport slave (
    output cmd_valid,
    output cmd_type,
    output txn_done,
    input  cmd_ready,
    input  txn_start,
    input  txn_type
  );
endinterface

// File: rtl/easy_axi_txn_seq.sv
// Upstream command sequencer for the EASY_AXI master.
// Queues write/read commands in a small registered FIFO and issues them one at a time as a
// txn_start strobe plus txn_type, waiting for txn_done (or a watchdog timeout) between issues.
// Optional feature macro: EASY_AXI_SEQ_STATS_EN enables the completion/discard counters;
// without it wr_done_cnt_o, rd_done_cnt_o and bad_cnt_o are tied to zero.
module easy_axi_txn_seq #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned START_CYCLES   = 5,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  easy_axi_txn_seq_if.master            bus,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          err_timeout_o,
  input  logic                          err_clr_i,
  output logic [CNT_WIDTH-1:0]          wr_done_cnt_o,
  output logic [CNT_WIDTH-1:0]          rd_done_cnt_o,
  output logic [CNT_WIDTH-1:0]          bad_cnt_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  // One timer serves the START strobe length, the watchdog and the GAP length.
  localparam int unsigned TmrMax0 = (TIMEOUT_CYCLES > START_CYCLES) ? TIMEOUT_CYCLES
                                                                    : START_CYCLES;
  localparam int unsigned TmrMax  = (TmrMax0 > GAP_CYCLES) ? TmrMax0 : GAP_CYCLES;
  localparam int unsigned TmrW    = $clog2(TmrMax + 1);

  localparam logic [TmrW-1:0] StartLast = TmrW'(START_CYCLES - 1);
  localparam logic [TmrW-1:0] ToLast    = TmrW'(TIMEOUT_CYCLES - 1);
  localparam logic [TmrW-1:0] GapLast   = (GAP_CYCLES > 0) ? TmrW'(GAP_CYCLES - 1) : '0;
  localparam logic [LvlW-1:0] FullLvl   = LvlW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

  state_e state_q, state_d;

  logic [1:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [1:0]      txn_type_q, txn_type_d;
  logic            err_q, err_d;

  logic       fifo_full, fifo_empty, push, pop;
  logic [1:0] head;
  logic       head_valid;
  logic       in_txn, done_acc, tmo_hit, txn_end;
  state_e     exit_st;

  // FIFO status, handshake decode and transaction-end conditions.
  always_comb begin
    fifo_full  = (level_q == FullLvl);
    fifo_empty = (level_q == '0);
    push       = bus.cmd_valid && !fifo_full;
    pop        = (state_q == StIdle) && !fifo_empty;
    head       = mem_q[rd_ptr_q];
    head_valid = (head == 2'b01) || (head == 2'b10);
    in_txn     = (state_q == StStart) || (state_q == StWait);
    done_acc   = in_txn && bus.txn_done;
    // A done pulse on the watchdog's last cycle takes priority over the timeout.
    tmo_hit    = in_txn && !bus.txn_done && (tmr_q == ToLast);
    txn_end    = done_acc || tmo_hit;
    exit_st    = (GAP_CYCLES == 0) ? StIdle : StGap;
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.cmd_type;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LvlW'(1);
      end else if (!push && pop) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // Invalid heads are dropped here and the FSM stays in IDLE.
        if (pop && head_valid) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (txn_end) begin
          state_d = exit_st;
        end else if (tmr_q == StartLast) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (txn_end) begin
          state_d = exit_st;
        end
      end
      StGap: begin
        if (tmr_q == GapLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.txn_start = (state_q == StStart);
    bus.txn_type  = txn_type_q;
    bus.cmd_ready = !fifo_full;
    busy_o        = (state_q != StIdle) || !fifo_empty;
    fifo_level_o  = level_q;
    err_timeout_o = err_q;
  end

  // Timer, latched type and sticky timeout next-state.
  always_comb begin
    tmr_d = tmr_q;
    if (state_q == StIdle && state_d == StStart) begin
      tmr_d = '0;
    end else if (state_d == StGap && state_q != StGap) begin
      tmr_d = '0;
    end else if (state_q != StIdle) begin
      tmr_d = tmr_q + TmrW'(1);
    end

    txn_type_d = txn_type_q;
    if (state_q == StIdle && state_d == StStart) begin
      txn_type_d = head;
    end else if (txn_end) begin
      txn_type_d = 2'b00;
    end

    // Setting wins over a simultaneous clear.
    err_d = err_q;
    if (tmo_hit) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  // Timer, latched type and sticky timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q      <= '0;
      txn_type_q <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      tmr_q      <= tmr_d;
      txn_type_q <= txn_type_d;
      err_q      <= err_d;
    end
  end

`ifdef EASY_AXI_SEQ_STATS_EN
  logic [CNT_WIDTH-1:0] wr_cnt_q, rd_cnt_q, bad_cnt_q;

  // Completion and discard counters; they wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      bad_cnt_q <= '0;
    end else begin
      if (done_acc && txn_type_q == 2'b01) begin
        wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
      end
      if (done_acc && txn_type_q == 2'b10) begin
        rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(1);
      end
      if (pop && !head_valid) begin
        bad_cnt_q <= bad_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign wr_done_cnt_o = wr_cnt_q;
  assign rd_done_cnt_o = rd_cnt_q;
  assign bad_cnt_o     = bad_cnt_q;
`else
  assign wr_done_cnt_o = '0;
  assign rd_done_cnt_o = '0;
  assign bad_cnt_o     = '0;
`endif

endmodule
